// File: rtl/lcd_fill_scheduler.sv
// Rectangle-fill sequencer for the 240x135 ST7789 panel: emits CASET, RASET, RAMWR, then pixel bytes.
// Define LCD_FILL_CLIP_EN to swap/clamp out-of-order or oversized windows instead of rejecting them.
module lcd_fill_scheduler #(
  parameter int LCD_W    = 240,
  parameter int LCD_H    = 135,
  parameter int X_OFFSET = 40,
  parameter int Y_OFFSET = 53
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x0,
  input  logic [7:0]  req_x1,
  input  logic [7:0]  req_y0,
  input  logic [7:0]  req_y1,
  input  logic [15:0] req_color,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  output logic        tx_last,
  output logic        busy,
  output logic        done,
  output logic        req_err
);

  localparam logic [7:0]  X_MAX = 8'(LCD_W - 1);
  localparam logic [7:0]  Y_MAX = 8'(LCD_H - 1);
  localparam logic [15:0] X_OFF = 16'(X_OFFSET);
  localparam logic [15:0] Y_OFF = 16'(Y_OFFSET);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CASET_C, ST_CASET_D, ST_RASET_C, ST_RASET_D,
    ST_RAMWR_C, ST_PIX, ST_DONE, ST_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [7:0]  col_q, col_d, row_q, row_d;
  logic [15:0] color_q, color_d;
  logic [1:0]  idx_q, idx_d;
  logic        hi_q, hi_d;
  logic        req_ready_q, req_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_dc_q, tx_dc_d;
  logic        tx_last_q, tx_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        req_err_q, req_err_d;

  logic [7:0]  nx0, nx1, ny0, ny1;
  logic        req_ok;
  logic        xfer;
  logic [15:0] xs, xe, ys, ye;

`ifdef LCD_FILL_CLIP_EN
  always_comb begin
    nx0 = (req_x0 > req_x1) ? req_x1 : req_x0;
    nx1 = (req_x0 > req_x1) ? req_x0 : req_x1;
    ny0 = (req_y0 > req_y1) ? req_y1 : req_y0;
    ny1 = (req_y0 > req_y1) ? req_y0 : req_y1;
    if (nx1 > X_MAX) nx1 = X_MAX;
    if (nx0 > X_MAX) nx0 = X_MAX;
    if (ny1 > Y_MAX) ny1 = Y_MAX;
    if (ny0 > Y_MAX) ny0 = Y_MAX;
    req_ok = 1'b1;
  end
`else
  always_comb begin
    nx0    = req_x0;
    nx1    = req_x1;
    ny0    = req_y0;
    ny1    = req_y1;
    req_ok = (req_x0 <= req_x1) && (req_y0 <= req_y1) &&
             (req_x1 <= X_MAX) && (req_y1 <= Y_MAX);
  end
`endif

  function automatic logic [7:0] coord_byte(input logic [15:0] s, input logic [15:0] e,
                                            input logic [1:0] i);
    case (i)
      2'd0:    coord_byte = s[15:8];
      2'd1:    coord_byte = s[7:0];
      2'd2:    coord_byte = e[15:8];
      default: coord_byte = e[7:0];
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    col_d   = col_q;
    row_d   = row_q;
    color_d = color_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    xfer    = tx_valid_q && tx_ready;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          x0_d    = nx0;
          x1_d    = nx1;
          y0_d    = ny0;
          y1_d    = ny1;
          color_d = req_color;
          col_d   = nx0;
          row_d   = ny0;
          idx_d   = 2'd0;
          hi_d    = 1'b1;
          state_d = req_ok ? ST_CASET_C : ST_ERR;
        end
      end
      ST_CASET_C: if (xfer) state_d = ST_CASET_D;
      ST_CASET_D: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_RASET_C;
        end
      end
      ST_RASET_C: if (xfer) state_d = ST_RASET_D;
      ST_RASET_D: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_RAMWR_C;
        end
      end
      ST_RAMWR_C: begin
        if (xfer) begin
          col_d   = x0_q;
          row_d   = y0_q;
          hi_d    = 1'b1;
          state_d = ST_PIX;
        end
      end
      // Column is the inner loop; counters stop at x1/y1 rather than wrapping.
      ST_PIX: begin
        if (xfer) begin
          if (hi_q) begin
            hi_d = 1'b0;
          end else begin
            hi_d = 1'b1;
            if (col_q != x1_q) begin
              col_d = col_q + 8'd1;
            end else if (row_q != y1_q) begin
              col_d = x0_q;
              row_d = row_q + 8'd1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are derived from the next state so they register alongside it.
    xs         = {8'h00, x0_d} + X_OFF;
    xe         = {8'h00, x1_d} + X_OFF;
    ys         = {8'h00, y0_d} + Y_OFF;
    ye         = {8'h00, y1_d} + Y_OFF;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    tx_dc_d    = 1'b0;
    tx_last_d  = 1'b0;
    case (state_d)
      ST_CASET_C: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h2A;
        tx_last_d  = 1'b1;
      end
      ST_CASET_D: begin
        tx_valid_d = 1'b1;
        tx_data_d  = coord_byte(xs, xe, idx_d);
        tx_dc_d    = 1'b1;
        tx_last_d  = (idx_d == 2'd3);
      end
      ST_RASET_C: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h2B;
        tx_last_d  = 1'b1;
      end
      ST_RASET_D: begin
        tx_valid_d = 1'b1;
        tx_data_d  = coord_byte(ys, ye, idx_d);
        tx_dc_d    = 1'b1;
        tx_last_d  = (idx_d == 2'd3);
      end
      ST_RAMWR_C: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h2C;
      end
      ST_PIX: begin
        tx_valid_d = 1'b1;
        tx_data_d  = hi_d ? color_d[15:8] : color_d[7:0];
        tx_dc_d    = 1'b1;
        tx_last_d  = !hi_d && (col_d == x1_d) && (row_d == y1_d);
      end
      default: ;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
    done_d      = (state_d == ST_DONE);
    req_err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      x0_q        <= 8'h00;
      x1_q        <= 8'h00;
      y0_q        <= 8'h00;
      y1_q        <= 8'h00;
      col_q       <= 8'h00;
      row_q       <= 8'h00;
      color_q     <= 16'h0000;
      idx_q       <= 2'd0;
      hi_q        <= 1'b0;
      req_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_dc_q     <= 1'b0;
      tx_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      col_q       <= col_d;
      row_q       <= row_d;
      color_q     <= color_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      req_ready_q <= req_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_dc_q     <= tx_dc_d;
      tx_last_q   <= tx_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_err_q   <= req_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_dc     = tx_dc_q;
  assign tx_last   = tx_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_err   = req_err_q;

endmodule

// File: tb/tb_lcd_fill_scheduler.sv
// Scoreboard bench for lcd_fill_scheduler: expected {data,dc,last} bytes are queued per request
// and popped as the scheduler hands bytes to the (modelled) serializer.
`timescale 1ns/1ps
module tb_lcd_fill_scheduler;

  localparam int LCD_W = 240;
  localparam int LCD_H = 135;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_x0 = 8'h00, req_x1 = 8'h00, req_y0 = 8'h00, req_y1 = 8'h00;
  logic [15:0] req_color = 16'h0000;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_dc, tx_last, busy, done, req_err;

  int          pass_cnt = 0;
  int          check_cnt = 0;
  logic [9:0]  exp_q[$];
  int          byte_cnt = 0, done_cnt = 0, err_cnt = 0, ready_viol = 0;
  bit          rand_ready = 1'b0;
  bit          hold_pending = 1'b0;
  logic [9:0]  held = 10'h000;

  lcd_fill_scheduler dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
    .req_color(req_color),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_dc(tx_dc), .tx_last(tx_last),
    .busy(busy), .done(done), .req_err(req_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Reference model of the byte stream for one request.
  task automatic pushExpected(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] y0,
                              input logic [7:0] y1, input logic [15:0] color, output bit ok);
    logic [7:0]  a0, a1, b0, b1;
    logic [15:0] xs, xe, ys, ye;
    a0 = x0; a1 = x1; b0 = y0; b1 = y1;
`ifdef LCD_FILL_CLIP_EN
    if (x0 > x1) begin a0 = x1; a1 = x0; end
    if (y0 > y1) begin b0 = y1; b1 = y0; end
    if (a1 > 8'(LCD_W - 1)) a1 = 8'(LCD_W - 1);
    if (a0 > 8'(LCD_W - 1)) a0 = 8'(LCD_W - 1);
    if (b1 > 8'(LCD_H - 1)) b1 = 8'(LCD_H - 1);
    if (b0 > 8'(LCD_H - 1)) b0 = 8'(LCD_H - 1);
    ok = 1'b1;
`else
    ok = (x0 <= x1) && (y0 <= y1) && (int'(x1) < LCD_W) && (int'(y1) < LCD_H);
`endif
    if (ok) begin
      xs = 16'(a0) + 16'd40; xe = 16'(a1) + 16'd40;
      ys = 16'(b0) + 16'd53; ye = 16'(b1) + 16'd53;
      exp_q.push_back({8'h2A, 2'b01});
      exp_q.push_back({xs[15:8], 2'b10}); exp_q.push_back({xs[7:0], 2'b10});
      exp_q.push_back({xe[15:8], 2'b10}); exp_q.push_back({xe[7:0], 2'b11});
      exp_q.push_back({8'h2B, 2'b01});
      exp_q.push_back({ys[15:8], 2'b10}); exp_q.push_back({ys[7:0], 2'b10});
      exp_q.push_back({ye[15:8], 2'b10}); exp_q.push_back({ye[7:0], 2'b11});
      exp_q.push_back({8'h2C, 2'b00});
      for (int r = int'(b0); r <= int'(b1); r++) begin
        for (int c = int'(a0); c <= int'(a1); c++) begin
          exp_q.push_back({color[15:8], 2'b10});
          exp_q.push_back({color[7:0], 1'b1, (r == int'(b1)) && (c == int'(a1))});
        end
      end
    end
  endtask

  task automatic waitAccept(input int budget, output bit accepted);
    accepted = 1'b0;
    for (int i = 0; i < budget && !accepted; i++) begin
      @(negedge clk);
      accepted = req_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] y0,
                               input logic [7:0] y1, input logic [15:0] color);
    bit ok, accepted;
    @(posedge clk); #1;
    pushExpected(x0, x1, y0, y1, color, ok);
    req_x0 = x0; req_x1 = x1; req_y0 = y0; req_y1 = y1; req_color = color;
    req_valid = 1'b1;
    waitAccept(50, accepted);
    checkOutput("req_accepted", 32'(accepted), 32'd1);
    req_valid = 1'b0;
    req_x0 = 8'($urandom); req_x1 = 8'($urandom);
    req_y0 = 8'($urandom); req_y1 = 8'($urandom); req_color = 16'($urandom);
  endtask

  task automatic waitDrain(input int budget);
    int  n;
    bit  drained;
    n = 0;
    drained = 1'b0;
    while (!drained && n < budget) begin
      @(posedge clk); #2;
      n++;
      drained = (exp_q.size() == 0) && req_ready;
    end
    checkOutput("drain_in_time", 32'(drained), 32'd1);
  endtask

  // Serializer model: accepts bytes at negedge-sampled valid&&ready, checks hold stability.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        checkOutput("hold_stable", 32'({tx_valid, tx_data, tx_dc, tx_last}), 32'({1'b1, held}));
      if ((busy || done) && req_ready) ready_viol++;
      if (done) done_cnt++;
      if (req_err) err_cnt++;
      if (tx_valid && tx_ready) begin
        byte_cnt++;
        checkOutput("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          checkOutput("byte", 32'({tx_data, tx_dc, tx_last}), 32'(exp_q.pop_front()));
      end
      hold_pending = tx_valid && !tx_ready;
      held = {tx_data, tx_dc, tx_last};
    end
  end

  initial forever begin
    @(posedge clk); #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  bb, bd, be, bv, n;
    bit  ok, accepted, found;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_tx_dc", 32'(tx_dc), 32'd0);
    checkOutput("rst_tx_last", 32'(tx_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_req_err", 32'(req_err), 32'd0);
    resetn = 1'b1;

    $display("[TB] two-pixel fill");
    bb = byte_cnt; bd = done_cnt; be = err_cnt;
    applyStimulus(8'd0, 8'd1, 8'd0, 8'd0, 16'hF800);
    waitDrain(100);
    checkOutput("t1_bytes", 32'(byte_cnt - bb), 32'd15);
    checkOutput("t1_done", 32'(done_cnt - bd), 32'd1);
    checkOutput("t1_err", 32'(err_cnt - be), 32'd0);

    $display("[TB] full-screen fill");
    bb = byte_cnt; bd = done_cnt;
    applyStimulus(8'd0, 8'd239, 8'd0, 8'd134, 16'h07E0);
    waitDrain(70000);
    checkOutput("full_bytes", 32'(byte_cnt - bb), 32'd64811);
    checkOutput("full_done", 32'(done_cnt - bd), 32'd1);

    $display("[TB] corner pixel with random backpressure");
    bb = byte_cnt; bd = done_cnt;
    rand_ready = 1'b1;
    applyStimulus(8'd239, 8'd239, 8'd134, 8'd134, 16'h5A3C);
    waitDrain(500);
    rand_ready = 1'b0;
    checkOutput("corner_bytes", 32'(byte_cnt - bb), 32'd13);
    checkOutput("corner_done", 32'(done_cnt - bd), 32'd1);

    $display("[TB] reset during pixel stream");
    bb = byte_cnt;
    applyStimulus(8'd10, 8'd29, 8'd20, 8'd29, 16'h1234);
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      @(posedge clk); #2;
      n++;
      found = (byte_cnt - bb) == 110;
    end
    checkOutput("reach_pixel_100", 32'(found), 32'd1);
    checkOutput("pixel_100_valid", 32'({tx_valid, tx_dc}), 32'b11);
    resetn = 1'b0;
    #1;
    checkOutput("async_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #2;
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
    bb = byte_cnt; bd = done_cnt;
    applyStimulus(8'd5, 8'd5, 8'd7, 8'd7, 16'hABCD);
    waitDrain(100);
    checkOutput("post_rst_bytes", 32'(byte_cnt - bb), 32'd13);
    checkOutput("post_rst_done", 32'(done_cnt - bd), 32'd1);

    $display("[TB] reversed x window");
    bb = byte_cnt; bd = done_cnt; be = err_cnt;
    applyStimulus(8'd5, 8'd3, 8'd0, 8'd0, 16'h1111);
    waitDrain(100);
`ifdef LCD_FILL_CLIP_EN
    checkOutput("rev_bytes", 32'(byte_cnt - bb), 32'd17);
    checkOutput("rev_done", 32'(done_cnt - bd), 32'd1);
    checkOutput("rev_err", 32'(err_cnt - be), 32'd0);
`else
    checkOutput("rev_bytes", 32'(byte_cnt - bb), 32'd0);
    checkOutput("rev_done", 32'(done_cnt - bd), 32'd0);
    checkOutput("rev_err", 32'(err_cnt - be), 32'd1);
`endif

    $display("[TB] rows beyond panel height");
    bb = byte_cnt; bd = done_cnt; be = err_cnt;
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd135, 16'h2222);
    waitDrain(600);
`ifdef LCD_FILL_CLIP_EN
    checkOutput("tall_bytes", 32'(byte_cnt - bb), 32'd281);
    checkOutput("tall_err", 32'(err_cnt - be), 32'd0);
`else
    checkOutput("tall_bytes", 32'(byte_cnt - bb), 32'd0);
    checkOutput("tall_err", 32'(err_cnt - be), 32'd1);
`endif

    $display("[TB] request valid held across two transactions");
    bb = byte_cnt; bd = done_cnt; bv = ready_viol;
    @(posedge clk); #1;
    pushExpected(8'd1, 8'd2, 8'd3, 8'd3, 16'hC0DE, ok);
    req_x0 = 8'd1; req_x1 = 8'd2; req_y0 = 8'd3; req_y1 = 8'd3; req_color = 16'hC0DE;
    req_valid = 1'b1;
    waitAccept(50, accepted);
    checkOutput("held_first_accept", 32'(accepted), 32'd1);
    pushExpected(8'd9, 8'd9, 8'd4, 8'd5, 16'hBEEF, ok);
    req_x0 = 8'd9; req_x1 = 8'd9; req_y0 = 8'd4; req_y1 = 8'd5; req_color = 16'hBEEF;
    waitAccept(200, accepted);
    checkOutput("held_second_accept", 32'(accepted), 32'd1);
    checkOutput("held_done_before_second", 32'(done_cnt - bd), 32'd1);
    req_valid = 1'b0;
    waitDrain(200);
    checkOutput("held_bytes", 32'(byte_cnt - bb), 32'd30);
    checkOutput("held_done", 32'(done_cnt - bd), 32'd2);
    checkOutput("held_ready_low_while_busy", 32'(ready_viol - bv), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
